// File: rtl/bus_exec_unit.sv
// Multi-cycle register-file datapath: a start/busy/done command runs LDY -> EXEC -> [ITER] -> WB.
// MUL/DIV iterate one bit per cycle using HI/LO as the working registers.
module bus_exec_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NREGS = 16,
   localparam int unsigned AW = $clog2(NREGS),
   localparam int unsigned SW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [AW-1:0]    ra,
   input  logic [AW-1:0]    rb,
   input  logic [AW-1:0]    rc,
   input  logic [WIDTH-1:0] imm,
   input  logic             use_imm,
   input  logic             ba_mode,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             flag_err
);

   localparam logic [3:0] OpAdd = 4'd0, OpSub = 4'd1, OpAnd = 4'd2, OpOr = 4'd3;
   localparam logic [3:0] OpShl = 4'd4, OpShr = 4'd5, OpShra = 4'd6, OpRol = 4'd7;
   localparam logic [3:0] OpRor = 4'd8, OpNeg = 4'd9, OpNot = 4'd10, OpMul = 4'd11;
   localparam logic [3:0] OpDiv = 4'd12, OpMfhi = 4'd13, OpMflo = 4'd14;

   typedef enum logic [2:0] {StIdle, StLdy, StExec, StIter, StWb} state_e;

   state_e state_q, state_d;
   logic [WIDTH-1:0] regs_q [NREGS];
   logic [3:0]       op_q, op_d;
   logic [AW-1:0]    ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
   logic [WIDTH-1:0] imm_q, imm_d;
   logic             use_imm_q, use_imm_d, ba_q, ba_d;
   logic [WIDTH-1:0] y_q, y_d, z_q, z_d, hi_q, hi_d, lo_q, lo_d, res_q, res_d;
   logic             err_q, err_d;
   logic [SW-1:0]    cnt_q, cnt_d;

   logic             rf_we;
   logic [AW-1:0]    rf_idx;
   logic [WIDTH-1:0] rf_wdata;

   logic [WIDTH-1:0]   opb, alu_res;
   logic [SW-1:0]      sh;
   logic [2*WIDTH-1:0] rol_w, ror_w;
   logic [WIDTH:0]     mul_sum, div_rem, div_diff;
   logic               writes_gpr;

   assign opb = use_imm_q ? imm_q : ((ba_q && rc_q == '0) ? '0 : regs_q[rc_q]);
   assign sh    = opb[SW-1:0];
   assign rol_w = {y_q, y_q} << sh;
   assign ror_w = {y_q, y_q} >> sh;

   // Shift-add step: optional add of multiplicand into HI, then {carry,HI,LO} >> 1.
   assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, y_q} : '0);
   // Restoring divide step: remainder in HI, quotient shifts into LO, divisor held in Z.
   assign div_rem  = {hi_q, lo_q[WIDTH-1]};
   assign div_diff = div_rem - {1'b0, z_q};

   assign writes_gpr = (op_q <= OpNot) || (op_q == OpMfhi) || (op_q == OpMflo);

   always_comb begin
      alu_res = '0;
      case (op_q)
         OpAdd:   alu_res = y_q + opb;
         OpSub:   alu_res = y_q - opb;
         OpAnd:   alu_res = y_q & opb;
         OpOr:    alu_res = y_q | opb;
         OpShl:   alu_res = y_q << sh;
         OpShr:   alu_res = y_q >> sh;
         OpShra:  alu_res = $signed(y_q) >>> sh;
         OpRol:   alu_res = rol_w[2*WIDTH-1:WIDTH];
         OpRor:   alu_res = ror_w[WIDTH-1:0];
         OpNeg:   alu_res = '0 - opb;
         OpNot:   alu_res = ~opb;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      ra_d      = ra_q;
      rb_d      = rb_q;
      rc_d      = rc_q;
      imm_d     = imm_q;
      use_imm_d = use_imm_q;
      ba_d      = ba_q;
      y_d       = y_q;
      z_d       = z_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      res_d     = res_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      rf_we     = 1'b0;
      rf_idx    = '0;
      rf_wdata  = '0;
      unique case (state_q)
         StIdle: begin
            if (wr_en) begin
               rf_we    = 1'b1;
               rf_idx   = wr_addr;
               rf_wdata = wr_data;
            end
            if (start) begin
               op_d      = op;
               ra_d      = ra;
               rb_d      = rb;
               rc_d      = rc;
               imm_d     = imm;
               use_imm_d = use_imm;
               ba_d      = ba_mode;
               err_d     = 1'b0;
               state_d   = StLdy;
            end
         end
         StLdy: begin
            y_d     = (ba_q && rb_q == '0) ? '0 : regs_q[rb_q];
            state_d = StExec;
         end
         StExec: begin
            state_d = StWb;
            cnt_d   = '0;
            if (op_q <= OpNot) begin
               z_d   = alu_res;
               res_d = alu_res;
            end else if (op_q == OpMul) begin
               hi_d    = '0;
               lo_d    = opb;
               state_d = StIter;
            end else if (op_q == OpDiv) begin
               if (opb == '0) begin
                  lo_d  = '1;
                  hi_d  = y_q;
                  res_d = '1;
                  err_d = 1'b1;
               end else begin
                  hi_d    = '0;
                  lo_d    = y_q;
                  z_d     = opb;
                  state_d = StIter;
               end
            end else if (op_q == OpMfhi) begin
               z_d   = hi_q;
               res_d = hi_q;
            end else if (op_q == OpMflo) begin
               z_d   = lo_q;
               res_d = lo_q;
            end else begin
               err_d = 1'b1;
            end
         end
         StIter: begin
            if (op_q == OpMul) begin
               {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
            end else if (!div_diff[WIDTH]) begin
               hi_d = div_diff[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = div_rem[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == SW'(WIDTH - 1)) begin
               res_d   = lo_d;
               state_d = StWb;
            end
         end
         StWb: begin
            if (writes_gpr) begin
               rf_we    = 1'b1;
               rf_idx   = ra_q;
               rf_wdata = z_q;
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q   <= StIdle;
         op_q      <= '0;
         ra_q      <= '0;
         rb_q      <= '0;
         rc_q      <= '0;
         imm_q     <= '0;
         use_imm_q <= 1'b0;
         ba_q      <= 1'b0;
         y_q       <= '0;
         z_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         res_q     <= '0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         ra_q      <= ra_d;
         rb_q      <= rb_d;
         rc_q      <= rc_d;
         imm_q     <= imm_d;
         use_imm_q <= use_imm_d;
         ba_q      <= ba_d;
         y_q       <= y_d;
         z_q       <= z_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         res_q     <= res_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         if (rf_we) regs_q[rf_idx] <= rf_wdata;
      end
   end

   assign dbg_data = regs_q[dbg_addr];
   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StWb);
   assign flag_err = done & err_q;
   assign result   = res_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_bus_exec_unit.sv
// Directed self-checking bench for bus_exec_unit (WIDTH=32, NREGS=16).
module tb_bus_exec_unit;

   logic        clk, clr, start, use_imm, ba_mode, wr_en;
   logic [3:0]  op, ra, rb, rc, wr_addr, dbg_addr;
   logic [31:0] imm, wr_data, dbg_data, result, hi, lo;
   logic        busy, done, flag_err;

   int n_tests = 0;
   int n_fail  = 0;

   bus_exec_unit dut (
      .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
      .imm(imm), .use_imm(use_imm), .ba_mode(ba_mode), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .busy(busy), .done(done), .result(result), .hi(hi), .lo(lo), .flag_err(flag_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Tasks are entered just after a negedge and return just after a negedge.
   task automatic host_write(input logic [3:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic read_reg(input logic [3:0] a, output logic [31:0] v);
      dbg_addr = a;
      #1 v = dbg_data;
   endtask

   // Returns in the done cycle; lat counts edges from the start-sampling edge.
   task automatic run_cmd(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [31:0] im, input logic ui,
                          input logic bam, output int lat, output logic [31:0] res,
                          output logic err, output logic [31:0] h, output logic [31:0] l);
      start = 1'b1; op = o; ra = a; rb = b; rc = c; imm = im; use_imm = ui; ba_mode = bam;
      @(posedge clk);
      lat = 1;
      forever begin
         @(negedge clk);
         start = 1'b0;
         wr_en = 1'b0;
         if (done) break;
         if (lat > 100) begin
            $display("FAIL timeout: no done after %0d cycles, required done", lat);
            n_fail++;
            break;
         end
         @(posedge clk);
         lat++;
      end
      res = result; err = flag_err; h = hi; l = lo;
   endtask

   int          lat, ndone, dlat, busy_drop;
   logic [31:0] res, h, l, v;
   logic        err;

   initial begin
      clr = 1'b0; start = 1'b0; op = '0; ra = '0; rb = '0; rc = '0; imm = '0;
      use_imm = 1'b0; ba_mode = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      dbg_addr = '0;
      #11;
      check_eq("rst_result", result, 0);
      check_eq("rst_hilo", {hi, lo}, 0);
      check_eq("rst_flags", {busy, done, flag_err}, 0);
      check_eq("rst_r0", dbg_data, 0);
      #1 clr = 1'b1;
      @(negedge clk);

      // 1: ADD
      host_write(4'd2, 32'd7);
      host_write(4'd3, 32'd5);
      run_cmd(4'd0, 4'd1, 4'd2, 4'd3, 0, 1'b0, 1'b0, lat, res, err, h, l);
      check_eq("add_lat", lat, 3);
      check_eq("add_result", res, 12);
      check_eq("add_err", err, 0);
      @(negedge clk);
      read_reg(4'd1, v);
      check_eq("add_r1", v, 12);
      check_eq("add_idle", busy, 0);

      // write in the same cycle as start is seen by the command
      wr_en = 1'b1; wr_addr = 4'd6; wr_data = 32'd20;
      run_cmd(4'd0, 4'd7, 4'd6, 4'd3, 0, 1'b0, 1'b0, lat, res, err, h, l);
      check_eq("wr_start_result", res, 25);

      // 2: MUL
      @(negedge clk);
      host_write(4'd2, 32'hFFFF_FFFF);
      run_cmd(4'd11, 4'd1, 4'd2, 4'd3, 32'd2, 1'b1, 1'b0, lat, res, err, h, l);
      check_eq("mul_lat", lat, 35);
      check_eq("mul_hi", h, 1);
      check_eq("mul_lo", l, 32'hFFFF_FFFE);
      check_eq("mul_result", res, 32'hFFFF_FFFE);
      @(negedge clk);
      read_reg(4'd1, v);
      check_eq("mul_r1_kept", v, 12);

      // 5: start/wr_en during MUL are ignored
      start = 1'b1; op = 4'd11; ra = 4'd1; rb = 4'd2; imm = 32'd3; use_imm = 1'b1;
      @(posedge clk);
      ndone = 0; dlat = 0; busy_drop = 0;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         start   = (c == 5 || c == 10);
         wr_en   = (c == 7);
         wr_addr = 4'd5;
         wr_data = 32'hDEAD;
         if (done) begin
            ndone++;
            if (ndone == 1) dlat = c;
         end
         if (c <= 35 && !busy) busy_drop++;
      end
      start = 1'b0; wr_en = 1'b0;
      check_eq("busy_ndone", ndone, 1);
      check_eq("busy_lat", dlat, 35);
      check_eq("busy_drop", busy_drop, 0);
      check_eq("busy_mul_lo", lo, 32'hFFFF_FFFD);
      read_reg(4'd5, v);
      check_eq("busy_wr_dropped", v, 0);

      // 3: DIV and divide by zero
      @(negedge clk);
      host_write(4'd2, 32'd100);
      host_write(4'd3, 32'd7);
      run_cmd(4'd12, 4'd1, 4'd2, 4'd3, 0, 1'b0, 1'b0, lat, res, err, h, l);
      check_eq("div_lat", lat, 35);
      check_eq("div_lo", l, 14);
      check_eq("div_hi", h, 2);
      check_eq("div_result_err", {res, 31'd0, err}, {32'd14, 32'd0});
      @(negedge clk);
      host_write(4'd3, 32'd0);
      run_cmd(4'd12, 4'd1, 4'd2, 4'd3, 0, 1'b0, 1'b0, lat, res, err, h, l);
      check_eq("div0_lat", lat, 3);
      check_eq("div0_lo", l, 32'hFFFF_FFFF);
      check_eq("div0_hi", h, 100);
      check_eq("div0_err", err, 1);

      // 4: ba_mode masks operand reads of R0
      @(negedge clk);
      host_write(4'd0, 32'd9);
      run_cmd(4'd0, 4'd4, 4'd0, 4'd0, 32'd3, 1'b1, 1'b1, lat, res, err, h, l);
      @(negedge clk);
      read_reg(4'd4, v);
      check_eq("ba_on_r4", v, 3);
      run_cmd(4'd0, 4'd4, 4'd0, 4'd0, 32'd3, 1'b1, 1'b0, lat, res, err, h, l);
      @(negedge clk);
      read_reg(4'd4, v);
      check_eq("ba_off_r4", v, 12);
      read_reg(4'd0, v);
      check_eq("dbg_r0", v, 9);

      // 7: SHRA, ROR, illegal op
      host_write(4'd2, 32'h8000_0001);
      run_cmd(4'd6, 4'd1, 4'd2, 4'd0, 32'd4, 1'b1, 1'b0, lat, res, err, h, l);
      check_eq("shra", res, 32'hF800_0000);
      @(negedge clk);
      run_cmd(4'd8, 4'd1, 4'd2, 4'd0, 32'd1, 1'b1, 1'b0, lat, res, err, h, l);
      check_eq("ror", res, 32'hC000_0000);
      @(negedge clk);
      run_cmd(4'd15, 4'd1, 4'd2, 4'd0, 32'd1, 1'b1, 1'b0, lat, res, err, h, l);
      check_eq("ill_err", err, 1);
      check_eq("ill_result", res, 32'hC000_0000);
      check_eq("ill_lat", lat, 3);

      // 6: asynchronous reset mid-DIV
      @(negedge clk);
      host_write(4'd3, 32'd7);
      host_write(4'd2, 32'd100);
      start = 1'b1; op = 4'd12; ra = 4'd1; rb = 4'd2; rc = 4'd3; use_imm = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 clr = 1'b0;
      #1;
      check_eq("clr_outs", {result, hi, lo}, 0);
      check_eq("clr_flags", {busy, done, flag_err}, 0);
      #7 clr = 1'b1;
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check_eq("clr_no_done", ndone, 0);
      read_reg(4'd2, v);
      check_eq("clr_rf", v, 0);
      host_write(4'd2, 32'd7);
      host_write(4'd3, 32'd5);
      run_cmd(4'd0, 4'd1, 4'd2, 4'd3, 0, 1'b0, 1'b0, lat, res, err, h, l);
      check_eq("post_clr_lat", lat, 3);
      check_eq("post_clr_result", res, 12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
